motor_cmd_transmitter: RTL
==========================

MOTOR_CMD_TRANSMITTER -- requirements
Module: motor_cmd_transmitter

Interface
REQ-001 SHALL have parameter BIT_CLKS, default 2, meaning Clk_In cycles per serial bit slot; legal range 1..255.
REQ-002 SHALL have parameter STOP_BITS, default 4, meaning trailing zero slots per frame; legal range 1..15.
REQ-003 SHALL have port Clk_In  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_In  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Send_En  input  1  request to transmit frames; level-sensitive.
REQ-006 SHALL have port Len, Ldir, Ren, Rdir  input  1 each  motor command: left enable, left direction, right enable, right direction.
REQ-007 SHALL have port Serial_Out  output  1  registered serial line to the receiver's Serial_In.
REQ-008 SHALL have port Busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port Frame_Done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-010 SHALL transmit frames of 3+4+1+STOP_BITS slots (12 by default), each slot held exactly BIT_CLKS cycles.
REQ-011 SHALL order each frame as start 1,0,1; payload Len,Ldir,Ren,Rdir (Len first); even parity over the 4 payload bits; then STOP_BITS zeros.
REQ-012 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL, in IDLE at a rising edge with Send_En=1, latch {Len,Ldir,Ren,Rdir} into a command register, enter START, and drive Serial_Out=1 from that edge: one cycle of latency.
REQ-014 SHALL ignore command-input changes after the latch edge until the next frame's latch edge.
REQ-015 SHALL advance START->DATA after 3 slots, DATA->PARITY after 4 slots, PARITY->STOP after 1 slot, and leave STOP after STOP_BITS slots.
REQ-016 SHALL, at the end of STOP with Send_En=1, latch a fresh command and go directly to START with no idle cycle (back-to-back frames); with Send_En=0 it SHALL go to IDLE.
REQ-017 SHALL complete the current frame when Send_En falls mid-frame; Send_En is sampled only in IDLE and on the last STOP cycle.
REQ-018 SHALL drive Serial_Out=0 in IDLE.
REQ-019 SHALL drive Busy=1 in every non-IDLE state, including across back-to-back frame boundaries.
REQ-020 SHALL pulse Frame_Done=1 for exactly the last cycle of the last STOP slot of every frame.
REQ-021 SHALL use a slot-cycle counter of ceil(log2(BIT_CLKS)) bits (minimum 1) wrapping at BIT_CLKS-1, and a slot index counter of 4 bits; no counter overflow occurs within legal parameters.
REQ-022 SHALL, with BIT_CLKS=1, change Serial_Out every cycle with no skipped or doubled slot.

Reset
REQ-023 SHALL, while Reset_In=0, force state IDLE, Serial_Out=0, Busy=0, Frame_Done=0, counters=0, command register=0, independent of Clk_In.
REQ-024 SHALL abort a frame on reset assertion mid-frame; the partial frame is not resumed.
REQ-025 SHALL start a new frame no earlier than the first rising edge after Reset_In deasserts with Send_En=1.

Structure
REQ-026 SHALL place the FSM state encoding, START_PATTERN=3'b101, and PAYLOAD_BITS=4 in the shared receiver/transmitter package so the Receiver decodes the same framing.
REQ-027 SHALL be a single module; one sub-module, slot_timer (slot-cycle counter emitting a slot-end strobe), is permitted.

Verification
REQ-028 Reset: Reset_In=0 mid-frame with Send_En=1 -> Serial_Out, Busy, Frame_Done go 0 without a clock edge; IDLE after release.
REQ-029 Single frame: BIT_CLKS=2, command 1010, Send_En high one cycle -> Serial_Out 1,0,1,1,0,1,0,0,0,0,0,0 with 2 cycles per slot (24 cycles), Busy high 24 cycles, Frame_Done on cycle 24.
REQ-030 Parity: command 1110 -> parity slot 1; command 0000 -> parity 0 with no start-pattern corruption.
REQ-031 Back-to-back: Send_En held high, command changed 1010->0101 mid-frame -> first frame carries 1010; second frame starts the cycle after Frame_Done, carries 0101 with parity 0; Busy never drops.
REQ-032 Early release: Send_En dropped at slot 5 -> full 12-slot frame completes, then IDLE with Serial_Out=0.
REQ-033 Edge timing: BIT_CLKS=1, command 1111 -> 12-cycle frame 1,0,1,1,1,1,1,0,0,0,0,0.

Source files
------------

// File: rtl/motor_cmd_pkg.sv
// Shared framing definitions for the motor command link.
// Used by both the transmitter and the receiver.
package motor_cmd_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [2:0] START_PATTERN = 3'b101;
  localparam int START_BITS   = 3;
  localparam int PAYLOAD_BITS = 4;

  function automatic logic even_parity(
    input logic [PAYLOAD_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Counts clock cycles inside one serial slot.
// Emits slot_end on the last cycle of each slot.
module slot_timer #(
  parameter int BIT_CLKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic slot_end
);

  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);

  logic [CW-1:0] cnt;

  assign slot_end = run && (cnt == LAST);

  // Free-run while a frame is active, wrap on slot end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/motor_cmd_transmitter.sv
// Serialises a 4-bit motor command into framed slots:
// start 101, payload, even parity, trailing zeros.
module motor_cmd_transmitter
  import motor_cmd_pkg::*;
#(
  parameter int BIT_CLKS  = 2,
  parameter int STOP_BITS = 4
) (
  input  logic Clk_In,
  input  logic Reset_In,
  input  logic Send_En,
  input  logic Len,
  input  logic Ldir,
  input  logic Ren,
  input  logic Rdir,
  output logic Serial_Out,
  output logic Busy,
  output logic Frame_Done
);

  localparam logic [3:0] START_LAST = 4'(START_BITS - 1);
  localparam logic [3:0] DATA_LAST  = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0] STOP_LAST  = 4'(STOP_BITS - 1);

  logic [2:0] state;
  logic [2:0] nxt_state;
  logic [3:0] idx;
  logic [3:0] nxt_idx;
  logic [PAYLOAD_BITS-1:0] cmd;
  logic [PAYLOAD_BITS-1:0] nxt_cmd;
  logic [PAYLOAD_BITS-1:0] new_cmd;
  logic slot_end;
  logic nxt_bit;
  logic [1:0] sel;

  assign new_cmd = {Len, Ldir, Ren, Rdir};

  slot_timer #(
    .BIT_CLKS(BIT_CLKS)
  ) u_timer (
    .clk     (Clk_In),
    .rst_n   (Reset_In),
    .run     (state != ST_IDLE),
    .slot_end(slot_end)
  );

  // Frame sequencing; Send_En only matters in IDLE or at frame end.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cmd   = cmd;
    unique case (1'b1)
      state == ST_IDLE: begin
        if (Send_En) begin
          nxt_state = ST_START;
          nxt_idx   = '0;
          nxt_cmd   = new_cmd;
        end
      end
      state == ST_START: begin
        if (slot_end) begin
          if (idx == START_LAST) begin
            nxt_state = ST_DATA;
            nxt_idx   = '0;
          end else begin
            nxt_idx = idx + 4'd1;
          end
        end
      end
      state == ST_DATA: begin
        if (slot_end) begin
          if (idx == DATA_LAST) begin
            nxt_state = ST_PARITY;
            nxt_idx   = '0;
          end else begin
            nxt_idx = idx + 4'd1;
          end
        end
      end
      state == ST_PARITY: begin
        if (slot_end) begin
          nxt_state = ST_STOP;
          nxt_idx   = '0;
        end
      end
      state == ST_STOP: begin
        if (slot_end) begin
          if (idx == STOP_LAST) begin
            nxt_idx = '0;
            if (Send_En) begin
              nxt_state = ST_START;
              nxt_cmd   = new_cmd;
            end else begin
              nxt_state = ST_IDLE;
            end
          end else begin
            nxt_idx = idx + 4'd1;
          end
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_idx   = '0;
      end
    endcase
  end

  // Line level for the slot about to begin.
  always_comb begin
    nxt_bit = 1'b0;
    sel     = 2'd0;
    unique case (1'b1)
      nxt_state == ST_START: begin
        sel     = 2'd2 - nxt_idx[1:0];
        nxt_bit = START_PATTERN[sel];
      end
      nxt_state == ST_DATA: begin
        sel     = 2'd3 - nxt_idx[1:0];
        nxt_bit = nxt_cmd[sel];
      end
      nxt_state == ST_PARITY: begin
        nxt_bit = even_parity(nxt_cmd);
      end
      default: begin
        nxt_bit = 1'b0;
      end
    endcase
  end

  // State, slot index, command latch and registered line.
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cmd        <= '0;
      Serial_Out <= 1'b0;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      cmd        <= nxt_cmd;
      Serial_Out <= nxt_bit;
    end
  end

  assign Busy       = (state != ST_IDLE);
  assign Frame_Done = (state == ST_STOP) && (idx == STOP_LAST)
                    && slot_end;

endmodule
